// File: rtl/vga_pixel_streamer.sv
// ============================================================================
//  Module      : vga_pixel_streamer
//  Description : Avalon-MM fed pixel FIFO driving VGA timing, sync and colour
//                outputs. Optional colour-bar generator selected at build
//                time by the TEST_PATTERN_EN macro (ctrl bit1 = PAT).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_streamer #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        read,
    input  logic        chipselect,
    input  logic [7:0]  address,
    output logic [31:0] readdata,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        VGA_DE
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // h is at least 8 bits wide so the colour bars can always use h[7:5]
    localparam int c_HW = ($clog2(c_H_TOTAL + 1) < 8) ? 8 : $clog2(c_H_TOTAL + 1);
    localparam int c_VW = ($clog2(c_V_TOTAL + 1) < 1) ? 1 : $clog2(c_V_TOTAL + 1);
    localparam int c_DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;

    localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_HS_START = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_VS_START = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
    localparam logic [c_LW-1:0] c_LVL_FULL = c_LW'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic            r_en;
    logic [c_DW-1:0] r_div;
    logic [c_HW-1:0] r_h;
    logic [c_VW-1:0] r_v;
    logic [31:0]     r_frame_cnt;
    logic            r_underflow;
    logic            r_overflow;
    logic [c_LW-1:0] r_level;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [23:0]     r_mem [FIFO_DEPTH];
    logic [7:0]      r_red;
    logic [7:0]      r_green;
    logic [7:0]      r_blue;
    logic            r_hsync_n;
    logic            r_vsync_n;
    logic            r_de;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic        w_pat;
    logic        w_cs_wr, w_cs_rd;
    logic        w_push_req, w_ctrl_wr, w_flush_wr, w_stat_rd;
    logic        w_en_rise, w_en_fall;
    logic        w_tick, w_active, w_pix_tick;
    logic        w_empty, w_full;
    logic        w_pop, w_push, w_flush;
    logic        w_underrun, w_overrun;
    logic        w_hsync_n, w_vsync_n, w_vblank;
    logic [15:0] w_level16;
    logic [23:0] w_pop_data;
    logic        w_unused_bits;

`ifdef TEST_PATTERN_EN
    logic r_pat;
    assign w_pat = r_pat;
`else
    assign w_pat = 1'b0;
`endif

    assign w_cs_wr    = chipselect && write;
    assign w_cs_rd    = chipselect && read;
    assign w_push_req = w_cs_wr && (address == 8'd0);
    assign w_ctrl_wr  = w_cs_wr && (address == 8'd1);
    assign w_flush_wr = w_cs_wr && (address == 8'd3) && writedata[0];
    assign w_stat_rd  = w_cs_rd && (address == 8'd2);

    // Only a real change of EN matters; rewriting the same value is a no-op
    assign w_en_rise  = w_ctrl_wr && writedata[0] && !r_en;
    assign w_en_fall  = w_ctrl_wr && !writedata[0] && r_en;

    // A disabling write takes priority over a tick landing on the same edge
    assign w_tick     = r_en && (r_div == c_DIV_LAST) && !w_en_fall;
    assign w_active   = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_pix_tick = w_tick && w_active;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == c_LVL_FULL);
    assign w_pop      = w_pix_tick && !w_pat && !w_empty;
    assign w_underrun = w_pix_tick && !w_pat && w_empty;

    // Flush beats any push on the same edge, and that drop is not an overflow
    assign w_flush    = w_flush_wr || w_en_fall;
    assign w_push     = w_push_req && !w_flush && (!w_full || w_pop);
    assign w_overrun  = w_push_req && !w_flush && w_full && !w_pop;

    assign w_hsync_n  = !((r_h >= c_HS_START) && (r_h < c_HS_END));
    assign w_vsync_n  = !((r_v >= c_VS_START) && (r_v < c_VS_END));
    assign w_vblank   = (r_v >= c_V_ACT);
    assign w_level16  = 16'(r_level);
    assign w_pop_data = r_mem[r_rd_ptr];

    // Pad byte of the pixel word and spare ctrl bits carry no meaning here
    assign w_unused_bits = ^writedata[7:1];

    // Zero-wait register read mux; anything unmapped or unselected reads 0
    always_comb begin
        readdata = 32'd0;
        if (w_cs_rd) begin
            case (address)
                8'd1:    readdata = {30'd0, w_pat, r_en};
                8'd2:    readdata = {r_underflow, r_overflow, w_vblank, 13'd0, w_level16};
                8'd3:    readdata = r_frame_cnt;
                default: readdata = 32'd0;
            endcase
        end
    end

    // Control register: EN (and PAT when the pattern generator is built in)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en <= 1'b0;
`ifdef TEST_PATTERN_EN
            r_pat <= 1'b0;
`endif
        end else if (w_ctrl_wr) begin
            r_en <= writedata[0];
`ifdef TEST_PATTERN_EN
            r_pat <= writedata[1];
`endif
        end
    end

    // Sticky status flags: a new event on the clearing read edge keeps the flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_underflow <= w_underrun || (r_underflow && !w_stat_rd);
            r_overflow  <= w_overrun  || (r_overflow  && !w_stat_rd);
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage keeps only the colour bytes of each pixel word
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= writedata[31:8];
        end
    end

    // Tick divider, raster counters, frame counter and registered video outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div       <= '0;
            r_h         <= '0;
            r_v         <= '0;
            r_frame_cnt <= 32'd0;
            r_red       <= 8'd0;
            r_green     <= 8'd0;
            r_blue      <= 8'd0;
            r_de        <= 1'b0;
            r_hsync_n   <= 1'b1;
            r_vsync_n   <= 1'b1;
        end else if (w_en_fall) begin
            r_div     <= '0;
            r_h       <= '0;
            r_v       <= '0;
            r_red     <= 8'd0;
            r_green   <= 8'd0;
            r_blue    <= 8'd0;
            r_de      <= 1'b0;
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
        end else if (w_en_rise) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else if (r_en) begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_hsync_n <= w_hsync_n;
                r_vsync_n <= w_vsync_n;
                r_de      <= w_active;
                if (!w_active) begin
                    r_red   <= 8'd0;
                    r_green <= 8'd0;
                    r_blue  <= 8'd0;
                end else if (w_pat) begin
                    r_red   <= {8{r_h[5]}};
                    r_green <= {8{r_h[6]}};
                    r_blue  <= {8{r_h[7]}};
                end else if (w_empty) begin
                    r_red   <= 8'd0;
                    r_green <= 8'd0;
                    r_blue  <= 8'd0;
                end else begin
                    r_red   <= w_pop_data[23:16];
                    r_green <= w_pop_data[15:8];
                    r_blue  <= w_pop_data[7:0];
                end
                if (r_h == c_H_LAST) begin
                    r_h <= '0;
                    if (r_v == c_V_LAST) begin
                        r_v         <= '0;
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                    end else begin
                        r_v <= r_v + 1'b1;
                    end
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    assign VGA_R  = r_red;
    assign VGA_G  = r_green;
    assign VGA_B  = r_blue;
    assign HSYNC  = r_hsync_n;
    assign VSYNC  = r_vsync_n;
    assign VGA_DE = r_de;

endmodule

`default_nettype wire
